wb_select_unit: RTL and testbench
=================================

Name: wb_select_unit

Overview:
- Parametrised DM/WB pipeline-register stage.
- Picks the register-file write value from one of four sources: ALU result, data-memory load, PC link value, or an external variable-latency read port (peripheral/IO).
- Aligns and sign/zero-extends sub-word DM loads.
- Stalls the pipeline while an external read is outstanding, with a bounded timeout.
- Sits between the EX_DM pipeline registers and the register-file write port.

Parameters:
DATA_W, 16, datapath width in bits; multiple of 8, >= 16
PC_W, 16, PC width; must be <= DATA_W
REG_AW, 4, register-file address width
TIMEOUT, 64, max cycles to wait for ext_rdy before error completion; >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
valid_EX_DM  in  1  instruction present in EX_DM
flush_EX_DM  in  1  kill instruction in EX_DM (no write, abandons pending ext read)
src_sel_EX_DM  in  2  0=ALU, 1=DM, 2=PC link, 3=external
ld_size_EX_DM  in  2  DM load size: 0=word, 1=half, 2=byte, 3=word
ld_sext_EX_DM  in  1  1=sign-extend sub-word DM load
byte_off_EX_DM  in  log2(DATA_W/8)  byte offset of DM load within word
dst_EX_DM  in  DATA_W  ALU result
dm_rd_data_EX_DM  in  DATA_W  DM read word
pc_EX_DM  in  PC_W  link PC value
rf_we_EX_DM  in  1  instruction writes RF
rf_dst_addr_EX_DM  in  REG_AW  destination register
ext_rd_data  in  DATA_W  external read data, valid when ext_rdy=1
ext_rdy  in  1  external read data valid
stall_WB  out  1  combinational; hold EX_DM and earlier stages
ext_err  out  1  one-cycle pulse on ext-read timeout
rf_w_data_DM_WB  out  DATA_W  registered write data
rf_dst_addr_DM_WB  out  REG_AW  registered destination
rf_we_DM_WB  out  1  registered write enable

Behaviour:
- Reset: on rising clk with rst_n=0, all registered outputs = 0, ext_err = 0, state = IDLE, wait counter = 0. Reset overrides all other inputs, including mid-wait.
- Latency: one cycle, EX_DM inputs -> DM_WB outputs, for src 0/1/2, and for src 3 when ext_rdy=1 in the first cycle.
- "go" = valid_EX_DM & ~flush_EX_DM.
- On non-go cycles in IDLE: rf_we_DM_WB <= 0. Data and address registers may update but are don't-care.
- Source rules:
  - src 0 (ALU): dst_EX_DM.
  - src 2 (PC link): pc_EX_DM zero-extended to DATA_W.
  - src 1 (DM):
    - word (size 0 or 3): dm_rd_data unchanged; offset ignored.
    - half: shift right by 8*(byte_off & ~1), keep 16 bits.
    - byte: shift right by 8*byte_off, keep 8 bits.
    - Sub-word results: extend with the MSB if ld_sext=1, else zeros.
    - When DATA_W=16, half equals word.
- rf_we_DM_WB <= rf_we_EX_DM & go for completed instructions. rf_dst_addr_DM_WB <= rf_dst_addr_EX_DM.
- FSM IDLE:
  - go & src=3 & ext_rdy: capture ext_rd_data; stay IDLE; stall_WB=0.
  - go & src=3 & ~ext_rdy: stall_WB=1; rf_we_DM_WB <= 0 (bubble); counter <= 1; -> WAIT.
- FSM WAIT:
  - Upstream holds all EX_DM inputs stable. stall_WB = ~ext_rdy & ~flush_EX_DM. rf_we_DM_WB <= 0 each cycle waiting.
  - ext_rdy: write ext_rd_data with rf_we_EX_DM; counter <= 0; -> IDLE.
  - flush_EX_DM: no write; stall_WB=0; -> IDLE. Flush has priority over ext_rdy in the same cycle.
  - ~ext_rdy & counter == TIMEOUT-1: write all-ones data with rf_we_EX_DM; ext_err <= 1 for one cycle; stall_WB=0 that cycle; -> IDLE.
  - Otherwise counter++.
- Late ext_rdy after timeout or flush arrives in IDLE with no ext instruction pending: ignored.
- Back-to-back ext reads: each enters WAIT independently. No state carries over besides FSM.
- Flush in IDLE: bubble (rf_we_DM_WB <= 0).

Test Plan:
- ALU/PC/word DM, DATA_W=16, rf_we=1, dst=5: src0 dst=0x1234 -> next cycle rf_w_data=0x1234, we=1, addr=5; src2 pc=0x00A0 -> 0x00A0; src1 word dm=0xBEEF -> 0xBEEF.
- Byte loads: dm=0x80F1, off=1, sext=1 -> 0xFF80; same, sext=0 -> 0x0080; off=0, sext=1 -> 0xFFF1.
- Ext read, rdy after 3 cycles, data 0x5A5A: stall_WB high exactly 3 cycles, we=0 during stall, then one write of 0x5A5A, stall low.
- Ext read with rdy never asserted, TIMEOUT=8: stall for 7 cycles, then write 0xFFFF and a single ext_err pulse; subsequent ALU op completes normally.
- Flush during WAIT, with ext_rdy asserted the same cycle: no write, stall drops, FSM IDLE; a later stray ext_rdy causes no write.
- rst_n=0 mid-WAIT: all outputs 0 next cycle, stall_WB=0, FSM IDLE; a new ALU op after release writes correctly.

Source files
------------

// File: rtl/wb_select_unit.sv
// DM/WB pipeline register stage: selects the register-file write value from ALU,
// aligned DM load, PC link or a variable-latency external read, stalling while the latter is outstanding.
module wb_select_unit #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 16,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_EX_DM,
    input  logic                          flush_EX_DM,
    input  logic [1:0]                    src_sel_EX_DM,
    input  logic [1:0]                    ld_size_EX_DM,
    input  logic                          ld_sext_EX_DM,
    input  logic [$clog2(DATA_W/8)-1:0]   byte_off_EX_DM,
    input  logic [DATA_W-1:0]             dst_EX_DM,
    input  logic [DATA_W-1:0]             dm_rd_data_EX_DM,
    input  logic [PC_W-1:0]               pc_EX_DM,
    input  logic                          rf_we_EX_DM,
    input  logic [REG_AW-1:0]             rf_dst_addr_EX_DM,
    input  logic [DATA_W-1:0]             ext_rd_data,
    input  logic                          ext_rdy,
    output logic                          stall_WB,
    output logic                          ext_err,
    output logic [DATA_W-1:0]             rf_w_data_DM_WB,
    output logic [REG_AW-1:0]             rf_dst_addr_DM_WB,
    output logic                          rf_we_DM_WB
);

    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int CNT_W = $clog2(TIMEOUT+1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_w_data;
    logic [REG_AW-1:0]   r_dst_addr;
    logic                r_we;
    logic                r_ext_err;

    logic                w_go;
    logic                w_ext_sel;
    logic                w_timeout;
    logic                w_stall;
    logic [OFF_W-1:0]    w_half_off;
    logic [DATA_W-1:0]   w_half_word;
    logic [DATA_W-1:0]   w_byte_word;
    logic [DATA_W-1:0]   w_ld_data;
    logic [DATA_W-1:0]   w_sel_data;

    assign w_go      = valid_EX_DM & ~flush_EX_DM;
    assign w_ext_sel = (src_sel_EX_DM == 2'd3);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT-1));

    // Align and extend sub-word DM loads; halfwords always start on an even byte
    always_comb begin
        w_half_off  = byte_off_EX_DM & ~OFF_W'(1'b1);
        w_half_word = dm_rd_data_EX_DM >> {w_half_off, 3'b000};
        w_byte_word = dm_rd_data_EX_DM >> {byte_off_EX_DM, 3'b000};
        case (ld_size_EX_DM)
            2'd1: begin
                if (ld_sext_EX_DM) begin
                    w_ld_data = DATA_W'($signed(w_half_word[15:0]));
                end else begin
                    w_ld_data = DATA_W'(w_half_word[15:0]);
                end
            end
            2'd2: begin
                if (ld_sext_EX_DM) begin
                    w_ld_data = DATA_W'($signed(w_byte_word[7:0]));
                end else begin
                    w_ld_data = DATA_W'(w_byte_word[7:0]);
                end
            end
            default: w_ld_data = dm_rd_data_EX_DM;
        endcase
    end

    // Write-value source mux
    always_comb begin
        case (src_sel_EX_DM)
            2'd0:    w_sel_data = dst_EX_DM;
            2'd1:    w_sel_data = w_ld_data;
            2'd2:    w_sel_data = DATA_W'(pc_EX_DM);
            2'd3:    w_sel_data = ext_rd_data;
            default: w_sel_data = dst_EX_DM;
        endcase
    end

    // Stall is released on the completing cycle (data, flush or timeout)
    always_comb begin
        case (r_state)
            S_IDLE:  w_stall = w_go & w_ext_sel & ~ext_rdy;
            S_WAIT:  w_stall = ~ext_rdy & ~flush_EX_DM & ~w_timeout;
            default: w_stall = 1'b0;
        endcase
    end

    // Pipeline register and external-read wait FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_w_data   <= {DATA_W{1'b0}};
            r_dst_addr <= {REG_AW{1'b0}};
            r_we       <= 1'b0;
            r_ext_err  <= 1'b0;
        end else begin
            r_ext_err  <= 1'b0;
            r_dst_addr <= rf_dst_addr_EX_DM;
            case (r_state)
                S_IDLE: begin
                    r_w_data <= w_sel_data;
                    if (w_go & w_ext_sel & ~ext_rdy) begin
                        r_we    <= 1'b0;
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_WAIT;
                    end else begin
                        r_we    <= rf_we_EX_DM & w_go;
                    end
                end
                S_WAIT: begin
                    if (flush_EX_DM) begin
                        r_we    <= 1'b0;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= S_IDLE;
                    end else if (ext_rdy) begin
                        r_w_data <= ext_rd_data;
                        r_we     <= rf_we_EX_DM;
                        r_cnt    <= {CNT_W{1'b0}};
                        r_state  <= S_IDLE;
                    end else if (w_timeout) begin
                        // Error completion: the destination still gets written, with all-ones
                        r_w_data  <= {DATA_W{1'b1}};
                        r_we      <= rf_we_EX_DM;
                        r_ext_err <= 1'b1;
                        r_cnt     <= {CNT_W{1'b0}};
                        r_state   <= S_IDLE;
                    end else begin
                        r_we    <= 1'b0;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_we    <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_WB          = w_stall;
    assign ext_err           = r_ext_err;
    assign rf_w_data_DM_WB   = r_w_data;
    assign rf_dst_addr_DM_WB = r_dst_addr;
    assign rf_we_DM_WB       = r_we;

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed plus randomized bench for wb_select_unit (DATA_W=16, TIMEOUT=8) against a cycle-level reference model.
module tb_wb_select_unit;

    localparam int DW = 16;
    localparam int PW = 16;
    localparam int AW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid, flush;
    logic [1:0]    src, size;
    logic          sext;
    logic [0:0]    off;
    logic [DW-1:0] dst, dm;
    logic [PW-1:0] pc;
    logic          we_in;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] ext_data;
    logic          rdy;

    logic          stall, err, we_out;
    logic [DW-1:0] wdata;
    logic [AW-1:0] waddr;

    wb_select_unit #(.DATA_W(DW), .PC_W(PW), .REG_AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_EX_DM(valid), .flush_EX_DM(flush),
        .src_sel_EX_DM(src), .ld_size_EX_DM(size), .ld_sext_EX_DM(sext),
        .byte_off_EX_DM(off), .dst_EX_DM(dst), .dm_rd_data_EX_DM(dm),
        .pc_EX_DM(pc), .rf_we_EX_DM(we_in), .rf_dst_addr_EX_DM(addr_in),
        .ext_rd_data(ext_data), .ext_rdy(rdy),
        .stall_WB(stall), .ext_err(err),
        .rf_w_data_DM_WB(wdata), .rf_dst_addr_DM_WB(waddr), .rf_we_DM_WB(we_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    // Reference model state: is an external read outstanding, and how many stall cycles it has used
    bit m_pending = 1'b0;
    int m_wait = 0;

    always @(negedge clk) if (stall === 1'b1) stall_cnt++;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Value a completed non-stalling instruction should write
    function automatic logic [15:0] model_value();
        int v;
        int sh;
        case (src)
            2'd0: return dst;
            2'd2: return pc;
            2'd3: return ext_data;
            default: begin
                if (size == 2'd1) begin
                    sh = (int'(off) / 2) * 16;
                    v = int'(dm >> sh) & 32'h0000_FFFF;
                    if (sext && v >= 32768) v = v - 65536;
                    return v[15:0];
                end else if (size == 2'd2) begin
                    sh = int'(off) * 8;
                    v = int'(dm >> sh) & 32'h0000_00FF;
                    if (sext && v >= 128) v = v - 256;
                    return v[15:0];
                end else begin
                    return dm;
                end
            end
        endcase
    endfunction

    task automatic drive(input logic v, input logic f, input logic [1:0] s, input logic [1:0] sz,
                         input logic sx, input logic o, input logic [15:0] d, input logic [15:0] m,
                         input logic [15:0] p, input logic w, input logic [3:0] a,
                         input logic [15:0] x, input logic r);
        valid = v; flush = f; src = s; size = sz; sext = sx; off = o;
        dst = d; dm = m; pc = p; we_in = w; addr_in = a; ext_data = x; rdy = r;
    endtask

    task automatic cycle(input string tag);
        bit   go, tmo, full;
        logic e_stall, e_we, e_err;
        logic [15:0] e_data;
        logic [3:0]  e_addr;
        #1;
        go = valid && !flush;
        e_stall = 1'b0; e_we = 1'b0; e_err = 1'b0; e_data = 16'h0000; e_addr = 4'h0; full = 1'b0;
        if (!rst_n) begin
            full = 1'b1;
            m_pending = 1'b0;
            m_wait = 0;
        end else if (m_pending) begin
            tmo = (m_wait == TO - 1);
            e_stall = !rdy && !flush && !tmo;
            chk({tag, ":stall"}, {15'd0, stall}, {15'd0, e_stall});
            e_addr = addr_in;
            if (flush) begin
                m_pending = 1'b0;
            end else if (rdy) begin
                e_we = we_in; e_data = ext_data; m_pending = 1'b0;
            end else if (tmo) begin
                e_we = we_in; e_data = 16'hFFFF; e_err = 1'b1; m_pending = 1'b0;
            end else begin
                m_wait++;
            end
        end else begin
            if (go && src == 2'd3 && !rdy) begin
                e_stall = 1'b1; m_pending = 1'b1; m_wait = 1;
            end else begin
                e_we = go && we_in; e_data = model_value(); e_addr = addr_in;
            end
            chk({tag, ":stall"}, {15'd0, stall}, {15'd0, e_stall});
        end
        full = full || e_we;
        @(posedge clk);
        #1;
        chk({tag, ":we"}, {15'd0, we_out}, {15'd0, e_we});
        chk({tag, ":err"}, {15'd0, err}, {15'd0, e_err});
        if (full) begin
            chk({tag, ":data"}, wdata, e_data);
            chk({tag, ":addr"}, {12'd0, waddr}, {12'd0, e_addr});
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cycle("rst0");
        cycle("rst1");
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h1234, 16'h0, 16'h0, 1'b1, 4'd5, 16'h0, 1'b0);
        cycle("alu");
        chk("alu_lit", wdata, 16'h1234);
        drive(1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h00A0, 1'b1, 4'd5, 16'h0, 1'b0);
        cycle("pc");
        chk("pc_lit", wdata, 16'h00A0);
        drive(1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1, 16'h0, 16'hBEEF, 16'h0, 1'b1, 4'd5, 16'h0, 1'b0);
        cycle("dm_word");
        chk("dm_word_lit", wdata, 16'hBEEF);
        drive(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 16'h0, 16'h80F1, 16'h0, 1'b1, 4'd5, 16'h0, 1'b0);
        cycle("byte_o1_s");
        chk("byte_o1_s_lit", wdata, 16'hFF80);
        drive(1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b1, 16'h0, 16'h80F1, 16'h0, 1'b1, 4'd5, 16'h0, 1'b0);
        cycle("byte_o1_z");
        chk("byte_o1_z_lit", wdata, 16'h0080);
        drive(1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 16'h0, 16'h80F1, 16'h0, 1'b1, 4'd5, 16'h0, 1'b0);
        cycle("byte_o0_s");
        chk("byte_o0_s_lit", wdata, 16'hFFF1);
        drive(1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 16'h0, 16'h80F1, 16'h0, 1'b1, 4'd5, 16'h0, 1'b0);
        cycle("half_s");
        chk("half_s_lit", wdata, 16'h80F1);

        // External read ready after three stall cycles
        drive(1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd7, 16'h5A5A, 1'b0);
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) cycle("ext_wait");
        rdy = 1'b1;
        cycle("ext_done");
        chk("ext_data_lit", wdata, 16'h5A5A);
        idle();
        cycle("ext_after");
        chk("ext_stall_cnt", stall_cnt[15:0], 16'd3);

        // External read that never becomes ready
        drive(1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd9, 16'h1111, 1'b0);
        stall_cnt = 0;
        for (int i = 0; i < TO; i++) cycle("tmo");
        chk("tmo_err_lit", {15'd0, err}, 16'd1);
        chk("tmo_data_lit", wdata, 16'hFFFF);
        drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h4321, 16'h0, 16'h0, 1'b1, 4'd2, 16'h0, 1'b0);
        cycle("tmo_alu");
        chk("tmo_stall_cnt", stall_cnt[15:0], 16'd7);

        // Flush while waiting, with ext_rdy in the same cycle, then a stray ext_rdy
        drive(1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd4, 16'h2222, 1'b0);
        cycle("fl_wait0");
        cycle("fl_wait1");
        flush = 1'b1; rdy = 1'b1;
        cycle("fl_flush");
        chk("fl_we_lit", {15'd0, we_out}, 16'd0);
        idle();
        rdy = 1'b1; ext_data = 16'h3333;
        cycle("fl_stray");

        // Reset in the middle of a wait
        drive(1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 4'd6, 16'h4444, 1'b0);
        for (int i = 0; i < 3; i++) cycle("rm_wait");
        rst_n = 1'b0;
        idle();
        cycle("rm_rst");
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0F0F, 16'h0, 16'h0, 1'b1, 4'd3, 16'h0, 1'b0);
        cycle("rm_alu");
        chk("rm_alu_lit", wdata, 16'h0F0F);

        // Randomized traffic; EX_DM fields are held while an external read is outstanding
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            if (!m_pending) begin
                valid   = ($urandom_range(0, 7) != 0);
                src     = 2'($urandom_range(0, 3));
                size    = 2'($urandom_range(0, 3));
                sext    = 1'($urandom_range(0, 1));
                off     = 1'($urandom_range(0, 1));
                dst     = 16'($urandom);
                dm      = 16'($urandom);
                pc      = 16'($urandom);
                we_in   = ($urandom_range(0, 3) != 0);
                addr_in = 4'($urandom_range(0, 15));
            end
            flush    = ($urandom_range(0, 7) == 0);
            rdy      = ($urandom_range(0, 3) == 0);
            ext_data = 16'($urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
